rls_coef_collector: RTL
=======================

Name: rls_coef_collector

Overview:
- Downstream consumer of the RLS datapath.
- Captures the serial coefficient stream (one nBits word per cycle while `write` is high) and assembles N words into a parallel vector.
- Compares each new vector against the previous one and flags convergence.
- Presents each completed vector through a valid/ready handshake to the host/output stage.

Parameters:
- N, 2, number of coefficients per frame.
- nBits, 32, word width; signed two's-complement 17.15 fixed point.
- THRESH, 32'h0000_0100, convergence threshold on |new-old| per coefficient, unsigned.
- CONV_ITERS, 3, consecutive small-delta frames required to assert `converged`.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- x  in  nBits  serial coefficient word.
- write  in  1  x valid this cycle.
- final  in  1  end-of-iteration pulse from RLS control.
- iterations  in  32  RLS iteration count, sampled with the frame.
- clear  in  1  synchronous clear of history, counters and flags.
- coef_ready  in  1  consumer accepts vector.
- coef_out  out  N*nBits  assembled vector; word k at [k*nBits +: nBits], first received word is k=0.
- coef_valid  out  1  vector available.
- iter_out  out  32  `iterations` latched on the last word of the frame.
- converged  out  1  convergence flag.
- overrun  out  1  sticky: word dropped while HOLD.
- short_frame  out  1  sticky: `final` arrived with partial frame.

Behaviour:
- Reset (reset=0, async): all outputs 0, idx=0, conv_cnt=0, have_prev=0, prev vector 0, state IDLE.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - write=1 stores x in slot 0, sets idx=1, goes to COLLECT.
  - If N==1, goes directly to HOLD.
- COLLECT:
  - Each write=1 stores x in slot idx and increments idx.
  - The word with idx==N-1 completes the frame: latch iterations, next state HOLD, idx=0.
  - write=0 cycles are allowed (gaps); the state holds.
- Delta (per word as stored):
  - d = sign-extend(x) - sign-extend(prev[idx]) in nBits+1 bits; |d| compared to THRESH.
  - frame_small = AND over the frame of (|d| <= THRESH).
  - frame_small is forced 0 when have_prev==0.
- On frame completion:
  - prev <= new vector; have_prev <= 1.
  - conv_cnt <= frame_small ? min(conv_cnt+1, CONV_ITERS) : 0.
  - converged = (conv_cnt == CONV_ITERS), registered.
- HOLD:
  - coef_valid=1 the cycle after the last word (latency 1 from the last write).
  - coef_out and iter_out are stable while coef_valid=1 and coef_ready=0.
  - coef_valid & coef_ready: transfer; next state IDLE; coef_valid=0 next cycle.
  - write=1 in HOLD: word dropped, overrun<=1. Exception: write=1 in the same cycle as the transfer starts a new frame at slot 0, with no drop.
- final:
  - In COLLECT with 0<idx (frame incomplete, and not completing this cycle): discard partial frame, idx=0, short_frame<=1, state IDLE; prev and conv_cnt unchanged.
  - final together with the completing write: normal completion, no flag.
  - Ignored in IDLE/HOLD.
- clear=1:
  - idx, conv_cnt, have_prev, converged, overrun and short_frame go to 0; state IDLE; coef_valid=0.
  - clear has priority over all other inputs.
- Reset mid-frame or in HOLD: immediate return to reset values; the partial vector is lost.

Test Plan:
- Stream N=2 words 32'h0001_8000, 32'hFFFF_0000 with write high two cycles, iterations=5 -> one cycle later coef_valid=1, coef_out=64'hFFFF0000_00018000, iter_out=5, converged=0.
- Four frames differing by 32'h0000_0080 per word, each accepted immediately -> converged=1 after the 4th frame (3 small-delta frames); next frame with delta 32'h0000_0200 -> converged=0.
- Hold coef_ready=0 for 5 cycles while write pulses once -> coef_out unchanged, overrun=1; coef_ready=1 -> transfer, coef_valid=0 next cycle, overrun stays 1 until clear.
- One word, then final -> short_frame=1, no coef_valid, idx=0; next full frame collects normally with slot 0 = first new word.
- Delta overflow: prev 32'h7FFF_FFFF, new 32'h8000_0000 -> |d|=2^32-1 > THRESH, conv_cnt=0, no wrap to a small value.
- Assert reset low mid-frame and during HOLD -> all outputs 0 asynchronously; after release, the first frame has have_prev=0, so converged is not asserted.

Source files
------------

// File: rtl/rls_coef_collector.sv
// Assembles N serial RLS coefficient words into a vector and tracks frame-to-frame convergence.
// Latency: coef_valid rises one cycle after the last word of a frame is written.
// Backpressure: vector held until coef_ready; words written while holding are dropped (overrun).
module rls_coef_collector #(
    parameter int          N          = 2,
    parameter int          nBits      = 32,
    parameter logic [31:0] THRESH     = 32'h0000_0100,
    parameter int          CONV_ITERS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [nBits-1:0]   x,
    input  logic               write,
    input  logic               final_pulse,
    input  logic [31:0]        iterations,
    input  logic               clear,
    input  logic               coef_ready,
    output logic [N*nBits-1:0] coef_out,
    output logic               coef_valid,
    output logic [31:0]        iter_out,
    output logic               converged,
    output logic               overrun,
    output logic               short_frame
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(CONV_ITERS + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [nBits-1:0] cur [N];
    logic [CW-1:0]    conv_cnt;
    logic             have_prev;
    logic             acc_small;

    logic               transfer, accept, last, discard;
    logic [nBits-1:0]   prev_word;
    logic [nBits:0]     d, absd;
    logic               small_now, acc_next, frame_small;
    logic [CW-1:0]      conv_next;
    logic [N*nBits-1:0] assembled;

    // coef_out doubles as the previous-frame history used for the delta.
    assign prev_word = coef_out[idx*nBits +: nBits];
    assign d         = {x[nBits-1], x} - {prev_word[nBits-1], prev_word};
    assign absd      = d[nBits] ? (~d + 1'b1) : d;
    assign small_now = (absd <= (nBits+1)'(THRESH));

    assign transfer = (state == HOLD) && coef_valid && coef_ready;
    assign accept   = write && ((state == IDLE) || (state == COLLECT) || transfer);
    assign last     = accept && (idx == LAST);
    assign discard  = (state == COLLECT) && final_pulse && !last;

    assign acc_next    = (idx == '0) ? small_now : (acc_small & small_now);
    assign frame_small = acc_next & have_prev;
    assign conv_next   = !frame_small ? CW'(0) :
                         (conv_cnt == CW'(CONV_ITERS)) ? conv_cnt : conv_cnt + 1'b1;

    always_comb begin
        assembled = '0;
        for (int k = 0; k < N; k++) begin
            assembled[k*nBits +: nBits] = (k == N - 1) ? x : cur[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            conv_cnt    <= '0;
            have_prev   <= 1'b0;
            acc_small   <= 1'b0;
            coef_out    <= '0;
            coef_valid  <= 1'b0;
            iter_out    <= '0;
            converged   <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
            for (int k = 0; k < N; k++) cur[k] <= '0;
        end else if (clear) begin
            state       <= IDLE;
            idx         <= '0;
            conv_cnt    <= '0;
            have_prev   <= 1'b0;
            coef_valid  <= 1'b0;
            converged   <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (transfer) begin
                coef_valid <= 1'b0;
                state      <= IDLE;
            end
            if (state == HOLD && write && !coef_ready) begin
                overrun <= 1'b1;
            end
            if (discard) begin
                idx         <= '0;
                short_frame <= 1'b1;
                state       <= IDLE;
            end else if (accept) begin
                cur[idx]  <= x;
                acc_small <= acc_next;
                if (last) begin
                    coef_out   <= assembled;
                    iter_out   <= iterations;
                    have_prev  <= 1'b1;
                    conv_cnt   <= conv_next;
                    converged  <= (conv_next == CW'(CONV_ITERS));
                    coef_valid <= 1'b1;
                    idx        <= '0;
                    state      <= HOLD;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= COLLECT;
                end
            end
        end
    end

endmodule
